// File: rtl/step_pulse_gen_pkg.sv
// Shared types and constants for the step/dir pulse generator.
package step_pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDirSet,
    StPulseHi,
    StPulseLo
  } step_state_e;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/step_pulse_gen_ramp.sv
// Trapezoidal/triangular period ramp: tracks current step period, accel step count and
// steps remaining in the move.
module step_pulse_gen_ramp #(
  parameter int unsigned PER_W     = 16,
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned PULSE_W   = 4,
  parameter int unsigned START_PER = 4000,
  parameter int unsigned ACCEL_DEC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step_done,
  input  logic [PER_W-1:0] i_cruise,
  input  logic [CNT_W-1:0] i_nsteps,
  output logic [PER_W-1:0] o_cur_per,
  output logic             o_last_step
);

  localparam logic [PER_W-1:0] MIN_PER = PER_W'(2 * PULSE_W);
  localparam logic [PER_W-1:0] START_P = PER_W'(START_PER);
  localparam logic [PER_W:0]   DEC_W   = (PER_W + 1)'(ACCEL_DEC);

  logic [PER_W-1:0] r_cur_per, r_cruise;
  logic [CNT_W-1:0] r_remaining, r_accel_cnt;
  logic [PER_W-1:0] w_cruise_clamp, w_cur_per_d;
  logic [CNT_W-1:0] w_rem_next, w_accel_cnt_d;
  logic [PER_W:0]   w_up, w_gap;

  assign w_cruise_clamp = (i_cruise < MIN_PER) ? MIN_PER : i_cruise;
  assign w_rem_next     = r_remaining - 1'b1;
  assign w_up           = {1'b0, r_cur_per} + DEC_W;
  assign w_gap          = {1'b0, r_cur_per - r_cruise};

  // Decel once the steps left fit inside the accel distance already travelled.
  always_comb begin
    w_cur_per_d   = r_cur_per;
    w_accel_cnt_d = r_accel_cnt;
    if (w_rem_next <= r_accel_cnt) begin
      if (r_cur_per < START_P) begin
        w_cur_per_d = (w_up > {1'b0, START_P}) ? START_P : w_up[PER_W-1:0];
      end
    end else if (r_cur_per > r_cruise) begin
      w_cur_per_d   = (w_gap <= DEC_W) ? r_cruise : r_cur_per - DEC_W[PER_W-1:0];
      w_accel_cnt_d = r_accel_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_per   <= '0;
      r_cruise    <= '0;
      r_remaining <= '0;
      r_accel_cnt <= '0;
    end else if (i_load) begin
      r_cruise    <= w_cruise_clamp;
      r_cur_per   <= (w_cruise_clamp > START_P) ? w_cruise_clamp : START_P;
      r_remaining <= i_nsteps;
      r_accel_cnt <= '0;
    end else if (i_step_done) begin
      r_cur_per   <= w_cur_per_d;
      r_accel_cnt <= w_accel_cnt_d;
      r_remaining <= w_rem_next;
    end
  end

  assign o_cur_per   = r_cur_per;
  assign o_last_step = (r_remaining == CNT_W'(1));

endmodule

// File: rtl/step_pulse_gen.sv
// Move-command front end for a STEP/DIR driver: DIR setup, fixed-width STEP pulses spaced by
// the ramp period, absolute position tracking and abort.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int unsigned POS_W     = 16,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned PULSE_W   = 4,
  parameter int unsigned DIR_SETUP = 4,
  parameter int unsigned START_PER = 4000,
  parameter int unsigned ACCEL_DEC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [POS_W-1:0] i_cmd_target,
  input  logic [PER_W-1:0] i_cmd_period,
  input  logic             i_abort,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_busy,
  output logic             o_done,
  output logic [POS_W-1:0] o_position
);

  localparam int unsigned      CNT_W    = POS_W + 1;
  localparam logic [PER_W-1:0] SETUP_LD = PER_W'(DIR_SETUP - 1);
  localparam logic [PER_W-1:0] HI_LD    = PER_W'(PULSE_W - 1);
  localparam logic [PER_W-1:0] LO_OFS   = PER_W'(PULSE_W + 1);

  step_state_e      r_state;
  logic [PER_W-1:0] r_timer;
  logic             r_step, r_dir, r_busy, r_done, r_ready, r_abort;
  logic [POS_W-1:0] r_pos;

  logic [CNT_W-1:0] w_dist, w_nsteps;
  logic [PER_W-1:0] w_cur_per;
  logic w_accept, w_dist_pos, w_timer_zero, w_abort_any, w_last_step;
  logic w_go_idle, w_go_hi, w_go_lo, w_step_done;

  // Sign-extended difference: a target across the wrap point travels the long way round.
  assign w_dist       = {i_cmd_target[POS_W-1], i_cmd_target} - {r_pos[POS_W-1], r_pos};
  assign w_dist_pos   = ~w_dist[POS_W] & (|w_dist);
  assign w_nsteps     = w_dist[POS_W] ? (~w_dist + 1'b1) : w_dist;
  assign w_accept     = (r_state == StIdle) & r_ready & i_cmd_valid;
  assign w_timer_zero = (r_timer == '0);
  assign w_abort_any  = i_abort | r_abort;

  always_comb begin
    w_go_idle = 1'b0;
    w_go_hi   = 1'b0;
    w_go_lo   = 1'b0;
    unique case (r_state)
      StDirSet: begin
        w_go_idle = i_abort;
        w_go_hi   = ~i_abort & w_timer_zero;
      end
      StPulseHi: begin
        w_go_idle = w_timer_zero & w_abort_any;
        w_go_lo   = w_timer_zero & ~w_abort_any;
      end
      StPulseLo: begin
        w_go_idle = i_abort | (w_timer_zero & w_last_step);
        w_go_hi   = ~i_abort & w_timer_zero & ~w_last_step;
      end
      default: ;
    endcase
  end

  assign w_step_done = (r_state == StPulseLo) & w_go_hi;

  step_pulse_gen_ramp #(
    .PER_W     (PER_W),
    .CNT_W     (CNT_W),
    .PULSE_W   (PULSE_W),
    .START_PER (START_PER),
    .ACCEL_DEC (ACCEL_DEC)
  ) u_ramp (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_accept & (|w_nsteps)),
    .i_step_done (w_step_done),
    .i_cruise    (i_cmd_period),
    .i_nsteps    (w_nsteps),
    .o_cur_per   (w_cur_per),
    .o_last_step (w_last_step)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_step  <= 1'b0;
      r_dir   <= DIR_NEG;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
      r_abort <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_go_idle) begin
        r_state <= StIdle;
        r_step  <= 1'b0;
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
        r_done  <= 1'b1;
        r_abort <= 1'b0;
      end else if (w_go_hi) begin
        r_state <= StPulseHi;
        r_step  <= 1'b1;
        r_timer <= HI_LD;
        r_pos   <= (r_dir == DIR_POS) ? r_pos + 1'b1 : r_pos - 1'b1;
      end else if (w_go_lo) begin
        r_state <= StPulseLo;
        r_step  <= 1'b0;
        r_timer <= w_cur_per - LO_OFS;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_ready <= 1'b1;
            if (w_accept) begin
              if (|w_nsteps) begin
                r_state <= StDirSet;
                r_dir   <= w_dist_pos ? DIR_POS : DIR_NEG;
                r_timer <= SETUP_LD;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
              end else begin
                r_done  <= 1'b1;
              end
            end
          end
          // An abort mid-pulse is remembered so the pulse still completes at full width.
          StPulseHi: begin
            r_abort <= r_abort | i_abort;
            r_timer <= r_timer - 1'b1;
          end
          default: r_timer <= r_timer - 1'b1;
        endcase
      end
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_step      = r_step;
  assign o_dir       = r_dir;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_position  = r_pos;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench: table of moves on a flat-profile instance plus ramp, abort and reset sequences.
module tb_step_pulse_gen;

  localparam int PULSE_W   = 4;
  localparam int DIR_SETUP = 4;

  typedef struct {
    logic signed [15:0] tgt;
    logic [15:0]        per;
    int                 n;
    logic               dir;
    int                 sp;
    int                 first;
    int                 done_c;
    logic signed [15:0] pos;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               cmd_valid, cmd_ready, cmd_abort, step, dir, busy, done;
  logic [15:0]        cmd_target, cmd_period;
  logic signed [15:0] position;

  logic               rp_valid, rp_ready, rp_abort, rp_step, rp_dir, rp_busy, rp_done;
  logic [15:0]        rp_target, rp_period;
  logic signed [15:0] rp_position;

  int n_err = 0;
  int n_checks = 0;

  int m_rises, m_first, m_sp_err, m_hi_err, m_dir_err, m_pos_err;
  int m_done_n, m_done_c, m_busy_err, m_ready_end;

  vec_t vecs[5];
  int   exp_sp[19];
  int   rp_rise[20];
  int   rp_n, rp_done_n, rp_done_c;
  logic rp_prev;
  logic signed [15:0] exp_start;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .POS_W(16), .PER_W(16), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP),
    .START_PER(100), .ACCEL_DEC(16)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_target (cmd_target),
    .i_cmd_period (cmd_period),
    .i_abort      (cmd_abort),
    .o_step       (step),
    .o_dir        (dir),
    .o_busy       (busy),
    .o_done       (done),
    .o_position   (position)
  );

  step_pulse_gen #(
    .POS_W(16), .PER_W(16), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP),
    .START_PER(400), .ACCEL_DEC(100)
  ) u_dut_rp (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (rp_valid),
    .o_cmd_ready  (rp_ready),
    .i_cmd_target (rp_target),
    .i_cmd_period (rp_period),
    .i_abort      (rp_abort),
    .o_step       (rp_step),
    .o_dir        (rp_dir),
    .o_busy       (rp_busy),
    .o_done       (rp_done),
    .o_position   (rp_position)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one move on u_dut and watches it to DONE plus a quiet tail.
  task automatic run_move(input logic signed [15:0] tgt, input logic [15:0] per,
                          input logic exp_dir, input int exp_per, input int abort_at,
                          input logic signed [15:0] start_pos);
    int   hi_len, last_rise;
    logic prev;
    logic signed [15:0] exp_p;
    m_rises = 0; m_first = -1; m_sp_err = 0; m_hi_err = 0; m_dir_err = 0; m_pos_err = 0;
    m_done_n = 0; m_done_c = -1; m_busy_err = 0; m_ready_end = 0;
    hi_len = 0; last_rise = 0;
    @(negedge clk);
    cmd_target = tgt;
    cmd_period = per;
    cmd_valid  = 1'b1;
    if (!cmd_ready) m_busy_err++;
    prev = step;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (c == 50) cmd_target = ~tgt;
      cmd_valid = (c >= 50 && c < 52 && m_done_n == 0);
      if (cmd_valid && cmd_ready) m_busy_err++;
      cmd_abort = (c == abort_at);
      if (step && !prev) begin
        m_rises++;
        if (m_first < 0) m_first = c;
        else if (c - last_rise != exp_per) m_sp_err++;
        last_rise = c;
        exp_p = start_pos + (exp_dir ? 16'(m_rises) : -16'(m_rises));
        if (position != exp_p) m_pos_err++;
        hi_len = 0;
      end
      if (step) hi_len++;
      if (!step && prev && hi_len != PULSE_W) m_hi_err++;
      if (m_done_n == 0 && dir !== exp_dir) m_dir_err++;
      if (done) begin
        m_done_n++;
        if (m_done_c < 0) begin
          m_done_c    = c;
          m_ready_end = int'(cmd_ready && !busy);
        end
      end
      prev = step;
      if (m_done_c >= 0 && c >= m_done_c + 20) break;
    end
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_abort = 1'b0; cmd_target = '0; cmd_period = '0;
    rp_valid = 1'b0; rp_abort = 1'b0; rp_target = '0; rp_period = '0;
    for (int i = 0; i < 20; i++) rp_rise[i] = 0;

    //          tgt     per   n  dir  sp  first done_c pos
    vecs[0] = '{16'sd5,  100, 5, 1'b1, 100, 5,   505,  16'sd5};
    vecs[1] = '{-16'sd3, 100, 8, 1'b0, 100, 5,   805,  -16'sd3};
    vecs[2] = '{-16'sd3, 100, 0, 1'b0, 100, -1,  1,    -16'sd3};
    vecs[3] = '{16'sd2,  200, 5, 1'b1, 200, 5,   1005, 16'sd2};
    vecs[4] = '{16'sd2,  50,  0, 1'b1, 100, -1,  1,    16'sd2};
    exp_sp = '{400, 300, 200, 100, 100, 100, 100, 100, 100, 100,
               100, 100, 100, 100, 100, 100, 100, 200, 300};

    // Reset state
    #12;
    check("rst step", int'(step), 0);
    check("rst dir", int'(dir), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst ready", int'(cmd_ready), 0);
    check("rst pos", int'(position), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready after release", int'(cmd_ready), 1);

    // Table of flat-profile moves
    exp_start = '0;
    for (int i = 0; i < 5; i++) begin
      run_move(vecs[i].tgt, vecs[i].per, vecs[i].dir, vecs[i].sp, -1, exp_start);
      check($sformatf("v%0d rises", i), m_rises, vecs[i].n);
      check($sformatf("v%0d first_rise", i), m_first, vecs[i].first);
      check($sformatf("v%0d spacing_errs", i), m_sp_err, 0);
      check($sformatf("v%0d width_errs", i), m_hi_err, 0);
      check($sformatf("v%0d dir_errs", i), m_dir_err, 0);
      check($sformatf("v%0d pos_at_rise_errs", i), m_pos_err, 0);
      check($sformatf("v%0d done_count", i), m_done_n, 1);
      check($sformatf("v%0d done_cycle", i), m_done_c, vecs[i].done_c);
      check($sformatf("v%0d ready_idle_at_done", i), m_ready_end, 1);
      check($sformatf("v%0d busy_accept_errs", i), m_busy_err, 0);
      check($sformatf("v%0d final_pos", i), int'(position), int'(vecs[i].pos));
      exp_start = vecs[i].pos;
    end

    // Ramp profile on the second instance
    rp_n = 0; rp_done_n = 0; rp_done_c = -1; rp_prev = 1'b0;
    @(negedge clk);
    rp_target = 16'd20;
    rp_period = 16'd100;
    rp_valid  = 1'b1;
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      rp_valid = 1'b0;
      if (rp_step && !rp_prev) begin
        if (rp_n < 20) rp_rise[rp_n] = c;
        rp_n++;
      end
      rp_prev = rp_step;
      if (rp_done) begin
        rp_done_n++;
        if (rp_done_c < 0) rp_done_c = c;
      end
      if (rp_done_c >= 0 && c >= rp_done_c + 10) break;
    end
    check("ramp rises", rp_n, 20);
    check("ramp first_rise", rp_rise[0], 1 + DIR_SETUP);
    for (int i = 0; i < 19; i++)
      check($sformatf("ramp spacing%0d", i), rp_rise[i+1] - rp_rise[i], exp_sp[i]);
    check("ramp done_cycle", rp_done_c, 3205);
    check("ramp done_count", rp_done_n, 1);
    check("ramp final_pos", int'(rp_position), 20);
    check("ramp dir", int'(rp_dir), 1);

    // Reset in the middle of a STEP pulse
    @(negedge clk);
    cmd_target = 16'd10;
    cmd_period = 16'd100;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 50 && !step; k++) @(negedge clk);
    check("midpulse step_high", int'(step), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midpulse rst step", int'(step), 0);
    check("midpulse rst pos", int'(position), 0);
    check("midpulse rst busy", int'(busy), 0);
    check("midpulse rst ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midpulse ready after release", int'(cmd_ready), 1);

    // Abort two cycles into the third STEP pulse
    run_move(16'sd10, 16'd100, 1'b1, 100, 206, 16'sd0);
    check("abort rises", m_rises, 3);
    check("abort width_errs", m_hi_err, 0);
    check("abort done_count", m_done_n, 1);
    check("abort done_cycle", m_done_c, 209);
    check("abort final_pos", int'(position), 3);
    check("abort busy_accept_errs", m_busy_err, 0);
    check("abort pos_at_rise_errs", m_pos_err, 0);

    // Normal single-step move after the abort
    run_move(16'sd4, 16'd100, 1'b1, 100, -1, 16'sd3);
    check("post rises", m_rises, 1);
    check("post done_cycle", m_done_c, 105);
    check("post final_pos", int'(position), 4);
    check("post done_count", m_done_n, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
